// File: rtl/shift_seq8_if.sv
// Request/result bundle of the 8-bit multi-cycle shifter.
// master drives a request, slave performs it and returns result and status.
interface shift_seq8_if;
  logic       start;
  logic       dir;
  logic [2:0] amount;
  logic [7:0] din;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       zero;

  modport master (
    output start, dir, amount, din,
    input  q, busy, done, zero
  );

  modport slave (
    input  start, dir, amount, din,
    output q, busy, done, zero
  );
endinterface

// File: rtl/shift_seq8.sv
// Multi-cycle logical shifter: loads an 8-bit operand and shifts it one bit
// per clock, left or right, for 0..7 steps. It pulses done when q is final.
module shift_seq8 (
  input  logic              clk,
  input  logic              rst_n,
  shift_seq8_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_reg;
  logic [7:0] q_reg;
  logic [2:0] cnt_reg;
  logic       dir_reg;

  // Single FSM holding the state, operand, remaining step count and the
  // latched direction. Requests are only taken in IDLE or DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      q_reg     <= 8'h00;
      cnt_reg   <= 3'd0;
      dir_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            q_reg     <= bus.din;
            cnt_reg   <= bus.amount;
            dir_reg   <= bus.dir;
            state_reg <= (bus.amount != 3'd0) ? SHIFT : DONE;
          end else begin
            // DONE only lasts one cycle; IDLE just holds q
            state_reg <= IDLE;
          end
        end
        SHIFT: begin
          // start is ignored here; the latched direction steers the step
          if (dir_reg) begin
            q_reg <= {q_reg[6:0], 1'b0};
          end else begin
            q_reg <= {1'b0, q_reg[7:1]};
          end
          cnt_reg <= cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) begin
            state_reg <= DONE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Status decodes straight off the state register, so they are glitch-free
  assign bus.busy = (state_reg == SHIFT);
  assign bus.done = (state_reg == DONE);
  assign bus.q    = q_reg;
  // zero follows q every cycle, including intermediate shift values
  assign bus.zero = (q_reg == 8'h00);

endmodule

// File: tb/tb_shift_seq8.sv
// Self-checking bench for shift_seq8: directed cases from the requirements
// plus randomized operations against a behavioural result model.
module tb_shift_seq8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  shift_seq8_if bus ();

  shift_seq8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result after n single-bit logical steps of the operand
  function automatic logic [7:0] model_shift(logic [7:0] d, logic dr, int n);
    logic [15:0] wide;
    wide = {8'h00, d};
    if (dr) return 8'(wide << n);
    else    return 8'(wide >> n);
  endfunction

  // Drive a request; takes effect on the next rising edge
  task automatic issue(input logic [7:0] d, input logic dr, input logic [2:0] a);
    bus.start  = 1'b1;
    bus.din    = d;
    bus.dir    = dr;
    bus.amount = a;
  endtask

  // Issue one operation and follow it edge by edge until its DONE cycle.
  // After edge j of the operation, q holds the operand shifted j times,
  // busy is high while j < amount and done is high exactly at j == amount.
  // With hold set, start stays high with random inputs during the shift.
  // Returns #1 after the edge that entered DONE, with start low.
  task automatic run_op(input string name, input logic [7:0] d, input logic dr,
                        input logic [2:0] a, input bit hold);
    logic [7:0] exp_q;
    issue(d, dr, a);
    @(posedge clk); #1;
    for (int j = 0; j <= int'(a); j++) begin
      exp_q = model_shift(d, dr, j);
      total++;
      if (bus.q !== exp_q || bus.busy !== (j < int'(a)) ||
          bus.done !== (j == int'(a)) || bus.zero !== (exp_q == 8'h00)) begin
        bad++;
        $display("FAIL %s step %0d: q=%h busy=%b done=%b zero=%b, expected q=%h busy=%b done=%b zero=%b",
                 name, j, bus.q, bus.busy, bus.done, bus.zero,
                 exp_q, (j < int'(a)), (j == int'(a)), (exp_q == 8'h00));
      end
      if (j < int'(a)) begin
        bus.start  = hold;
        bus.din    = 8'($urandom);
        bus.dir    = 1'($urandom);
        bus.amount = 3'($urandom);
        @(posedge clk); #1;
      end
    end
    bus.start  = 1'b0;
    bus.din    = 8'($urandom);
    bus.dir    = 1'($urandom);
    bus.amount = 3'($urandom);
    $display("op %s din=%h dir=%b amount=%0d -> q=%h", name, d, dr, a, bus.q);
  endtask

  // Idle cycles: q must hold, no status activity
  task automatic idle_check(input string name, input int n, input logic [7:0] exp_q);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      total++;
      if (bus.q !== exp_q || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL %s idle %0d: q=%h busy=%b done=%b, expected q=%h busy=0 done=0",
                 name, k, bus.q, bus.busy, bus.done, exp_q);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.zero !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: q=%h busy=%b done=%b zero=%b, expected 00 0 0 1",
               bus.q, bus.busy, bus.done, bus.zero);
    end
    $display("reset state q=%h busy=%b done=%b zero=%b", bus.q, bus.busy, bus.done, bus.zero);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_check("after_reset", 2, 8'h00);
  endtask

  task automatic test_right();
    run_op("right_b5_3", 8'hB5, 1'b0, 3'd3, 1'b0);
    total++;
    if (bus.q !== 8'h16 || bus.zero !== 1'b0) begin
      bad++;
      $display("FAIL right_result: q=%h zero=%b, expected q=16 zero=0", bus.q, bus.zero);
    end
    idle_check("right_hold", 2, 8'h16);
  endtask

  task automatic test_left();
    run_op("left_b5_7", 8'hB5, 1'b1, 3'd7, 1'b0);
    total++;
    if (bus.q !== 8'h80) begin
      bad++;
      $display("FAIL left7_result: q=%h, expected 80", bus.q);
    end
    idle_check("left7_hold", 1, 8'h80);
    run_op("left_b5_1", 8'hB5, 1'b1, 3'd1, 1'b0);
    total++;
    if (bus.q !== 8'h6A) begin
      bad++;
      $display("FAIL left1_result: q=%h, expected 6a", bus.q);
    end
    idle_check("left1_hold", 1, 8'h6A);
  endtask

  task automatic test_amount_zero();
    run_op("zero_amt_3c", 8'h3C, 1'b1, 3'd0, 1'b0);
    total++;
    if (bus.q !== 8'h3C) begin
      bad++;
      $display("FAIL amt0_result: q=%h, expected 3c", bus.q);
    end
    idle_check("amt0_hold", 1, 8'h3C);
    run_op("right_01_1", 8'h01, 1'b0, 3'd1, 1'b0);
    total++;
    if (bus.q !== 8'h00 || bus.zero !== 1'b1) begin
      bad++;
      $display("FAIL shift_out_zero: q=%h zero=%b, expected q=00 zero=1", bus.q, bus.zero);
    end
    idle_check("zero_hold", 1, 8'h00);
  endtask

  task automatic test_back_to_back();
    // start held high with random requests throughout the shift
    run_op("held_start_b5", 8'hB5, 1'b0, 3'd3, 1'b1);
    // new request in the DONE cycle; run_op checks busy right after the
    // accepting edge, so an IDLE gap would show up there
    run_op("b2b_ff_left2", 8'hFF, 1'b1, 3'd2, 1'b0);
    total++;
    if (bus.q !== 8'hFC) begin
      bad++;
      $display("FAIL b2b_result: q=%h, expected fc", bus.q);
    end
    idle_check("b2b_hold", 1, 8'hFC);
  endtask

  task automatic test_async_reset();
    issue(8'hA7, 1'b1, 3'd7);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.zero !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: q=%h busy=%b done=%b zero=%b, expected 00 0 0 1",
               bus.q, bus.busy, bus.done, bus.zero);
    end
    $display("async reset mid-shift q=%h busy=%b", bus.q, bus.busy);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 8'h00) begin
        bad++;
        $display("FAIL reset_no_done %0d: q=%h busy=%b done=%b, expected 00 0 0",
                 k, bus.q, bus.busy, bus.done);
      end
    end
    // release and request together: the very next edge must accept
    rst_n = 1'b1;
    run_op("post_reset_5a", 8'h5A, 1'b0, 3'd2, 1'b0);
    idle_check("post_reset_hold", 1, 8'h16);
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       dr;
    logic [2:0] a;
    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom);
      dr = 1'($urandom);
      a  = 3'($urandom_range(0, 7));
      run_op($sformatf("rand%0d", n), d, dr, a, 1'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        idle_check($sformatf("rand%0d_gap", n), $urandom_range(1, 3), model_shift(d, dr, int'(a)));
      end
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.dir    = 1'b0;
    bus.amount = 3'd0;
    bus.din    = 8'h00;
    test_reset();
    test_right();
    test_left();
    test_amount_zero();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_seq8.md
SHIFT_SEQ8 -- requirements
Module: shift_seq8

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 8 bits, shift count at 3 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new shift operation; sampled on rising clk.
REQ-005 dir  input  1  direction of the requested operation: 0 = logical right, 1 = logical left.
REQ-006 amount  input  3  number of 1-bit shift steps (0..7).
REQ-007 din  input  8  operand loaded when start is accepted.
REQ-008 q  output  8  registered operand/result; holds the final result after done.
REQ-009 busy  output  1  high while shift steps are in progress.
REQ-010 done  output  1  one-cycle pulse when the result in q is final.
REQ-011 zero  output  1  combinational flag, high when q == 8'h00.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE; busy = (state == SHIFT), done = (state == DONE).
REQ-013 Start SHALL be accepted only in IDLE or DONE; start in SHIFT SHALL be ignored with no effect on q, count, dir or state.
REQ-014 On acceptance: q <= din, cnt <= amount, dir latched internally; next state = SHIFT if amount != 0, else DONE.
REQ-015 Each clk edge in SHIFT: q <= q shifted one bit in latched dir, vacated bit = 0, cnt <= cnt - 1.
REQ-016 Right step: q[7] = 0, q[6:0] = q[7:1]; left step: q[7:1] = q[6:0], q[0] = 0; no rotate, no sign fill.
REQ-017 In SHIFT, when cnt == 1 at the edge, the last step SHALL be applied and next state = DONE.
REQ-018 Latency: done SHALL be high in the cycle starting amount+1 edges after the accepting edge (amount = 0 -> 1 edge).
REQ-019 busy SHALL be high for exactly amount cycles per operation; 0 cycles when amount = 0.
REQ-020 DONE SHALL last one cycle: next state = IDLE, or accept a new operation if start is high (back-to-back, no idle gap).
REQ-021 In IDLE and DONE without an accepted start, q SHALL hold its value.
REQ-022 Changes to dir, amount or din after acceptance SHALL NOT affect the operation in progress.
REQ-023 zero SHALL track q every cycle, including intermediate SHIFT values.

Reset
REQ-024 rst_n low SHALL immediately, without a clock edge, force state = IDLE, q = 8'h00, cnt = 0, latched dir = 0.
REQ-025 During reset: busy = 0, done = 0, zero = 1.
REQ-026 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-027 After rst_n deasserts, the first start SHALL be accepted on the first rising edge where rst_n is high.

Verification
REQ-028 Check right shift: din = 8'hB5, dir = 0, amount = 3 -> busy high 3 cycles, then done pulse 1 cycle, q = 8'h16, zero = 0.
REQ-029 Check left shift: din = 8'hB5, dir = 1, amount = 7 -> busy 7 cycles, then done, q = 8'h80; same din with amount = 1 -> q = 8'h6A.
REQ-030 Check amount = 0: din = 8'h3C -> no busy, done in the next cycle, q = 8'h3C; din = 8'h01, dir = 0, amount = 1 -> q = 8'h00, zero = 1.
REQ-031 Check start held high in SHIFT with new din/amount: ignored, result unchanged. Then start asserted in the DONE cycle with din = 8'hFF, dir = 1, amount = 2 -> next result 8'hFC, no IDLE cycle in between.
REQ-032 Check asynchronous reset: rst_n pulsed low mid-SHIFT between clock edges -> q = 8'h00, busy = 0 immediately, no done. Then a new start completes normally.
